// File: rtl/display_spi_sender.sv
// -----------------------------------------------------------------------------
// display_spi_sender
//   Display-side consumer of the stopwatch counter chain. After reset it runs
//   the MAX7219-style driver init sequence (5 frames). After that, each start
//   strobe accepted in IDLE snapshots the six BCD time digits (MM.SS.CC) and
//   sends them as six 16-bit SPI frames, address byte first, MSB first.
//
//   Frame shape (CD = CLK_DIV):
//     cs falls -> 16 x (CD cycles clk low, CD cycles clk high) -> CD cycles
//     tail (cs low, clk low) -> CD cycles gap (cs high) = 34*CD cycles.
//
// Ports
//   clk_in     system clock
//   res        asynchronous reset, active-high
//   start      one-cycle display-enable strobe (accepted only in IDLE)
//   min_X0..ces_0X  BCD digit inputs (sent unmodified, no clamping)
//   busy       high while the init or update sequence runs
//   init_done  sticky flag, set once the init sequence has completed
//   spi_cs     chip select, active-low, idle high
//   spi_clk    SPI clock, idle low, receiver samples on rising edge
//   spi_mosi   serial data, MSB first, 0 while spi_cs is high
// -----------------------------------------------------------------------------
module display_spi_sender #(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'hA
) (
    input  logic       clk_in,
    input  logic       res,
    input  logic       start,
    input  logic [2:0] min_X0,
    input  logic [3:0] min_0X,
    input  logic [2:0] sec_X0,
    input  logic [3:0] sec_0X,
    input  logic [3:0] ces_X0,
    input  logic [3:0] ces_0X,
    output logic       busy,
    output logic       init_done,
    output logic       spi_cs,
    output logic       spi_clk,
    output logic       spi_mosi
);

    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_RESET_WAIT, S_INIT, S_IDLE, S_UPDATE} state_t;
    typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_TAIL, PH_GAP} phase_t;

    // Driver init words, sent in index order.
    function automatic logic [15:0] init_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = 16'h0F00;
            3'd1:    w = 16'h0B05;
            3'd2:    w = 16'h09FF;
            3'd3:    w = {8'h0A, 4'h0, INTENSITY};
            default: w = 16'h0C01;
        endcase
        return w;
    endfunction

    // Snapshot layout: {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X}.
    // Data byte is {dp, 3'b000, bcd}; DP marks the digit before '.'.
    function automatic logic [15:0] upd_word(input logic [2:0] idx, input logic [21:0] s);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {8'h01, 4'h0,  s[3:0]};
            3'd1:    w = {8'h02, 4'h0,  s[7:4]};
            3'd2:    w = {8'h03, 4'h8,  s[11:8]};
            3'd3:    w = {8'h04, 5'h00, s[14:12]};
            3'd4:    w = {8'h05, 4'h8,  s[18:15]};
            default: w = {8'h06, 5'h00, s[21:19]};
        endcase
        return w;
    endfunction

    state_t        r_state, w_state_n;
    phase_t        r_ph,    w_ph_n;
    logic [DW-1:0] r_div,   w_div_n;
    logic [3:0]    r_bit,   w_bit_n;
    logic [2:0]    r_idx,   w_idx_n;
    logic [21:0]   r_snap,  w_snap_n;
    logic          r_cs,    w_cs_n;
    logic          r_sclk,  w_sclk_n;
    logic          r_mosi,  w_mosi_n;
    logic          r_busy,  w_busy_n;
    logic          r_done,  w_done_n;

    logic [21:0] w_live_snap;
    logic [15:0] w_init0, w_upd0, w_cur_word, w_next_word;
    logic        w_is_upd, w_last, w_div_end;

    assign w_live_snap = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};
    assign w_init0     = init_word(3'd0);
    // First update word comes from the live inputs: it is launched on the
    // same edge that captures the snapshot.
    assign w_upd0      = upd_word(3'd0, w_live_snap);
    assign w_is_upd    = (r_state == S_UPDATE);
    assign w_cur_word  = w_is_upd ? upd_word(r_idx, r_snap) : init_word(r_idx);
    assign w_next_word = w_is_upd ? upd_word(r_idx + 3'd1, r_snap) : init_word(r_idx + 3'd1);
    assign w_last      = w_is_upd ? (r_idx == 3'd5) : (r_idx == 3'd4);
    assign w_div_end   = (r_div == DIV_LAST);

    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            r_state <= S_RESET_WAIT;
            r_ph    <= PH_GAP;
            r_div   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ph    <= w_ph_n;
            r_div   <= w_div_n;
            r_bit   <= w_bit_n;
            r_idx   <= w_idx_n;
            r_snap  <= w_snap_n;
            r_cs    <= w_cs_n;
            r_sclk  <= w_sclk_n;
            r_mosi  <= w_mosi_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ph_n    = r_ph;
        w_div_n   = r_div;
        w_bit_n   = r_bit;
        w_idx_n   = r_idx;
        w_snap_n  = r_snap;
        w_cs_n    = r_cs;
        w_sclk_n  = r_sclk;
        w_mosi_n  = r_mosi;
        w_busy_n  = r_busy;
        w_done_n  = r_done;

        case (r_state)
            S_RESET_WAIT: begin
                w_state_n = S_INIT;
                w_busy_n  = 1'b1;
                w_idx_n   = 3'd0;
                w_cs_n    = 1'b0;
                w_sclk_n  = 1'b0;
                w_ph_n    = PH_LOW;
                w_div_n   = '0;
                w_bit_n   = 4'd15;
                w_mosi_n  = w_init0[15];
            end
            S_IDLE: begin
                if (start) begin
                    w_snap_n  = w_live_snap;
                    w_state_n = S_UPDATE;
                    w_busy_n  = 1'b1;
                    w_idx_n   = 3'd0;
                    w_cs_n    = 1'b0;
                    w_sclk_n  = 1'b0;
                    w_ph_n    = PH_LOW;
                    w_div_n   = '0;
                    w_bit_n   = 4'd15;
                    w_mosi_n  = w_upd0[15];
                end
            end
            default: begin
                // INIT and UPDATE share the frame engine.
                if (!w_div_end) begin
                    w_div_n = r_div + 1'b1;
                end else begin
                    w_div_n = '0;
                    case (r_ph)
                        PH_LOW: begin
                            w_ph_n   = PH_HIGH;
                            w_sclk_n = 1'b1;
                        end
                        PH_HIGH: begin
                            w_sclk_n = 1'b0;
                            if (r_bit == 4'd0) begin
                                w_ph_n = PH_TAIL;
                            end else begin
                                w_bit_n  = r_bit - 4'd1;
                                w_ph_n   = PH_LOW;
                                w_mosi_n = w_cur_word[r_bit - 4'd1];
                            end
                        end
                        PH_TAIL: begin
                            w_ph_n   = PH_GAP;
                            w_cs_n   = 1'b1;
                            w_mosi_n = 1'b0;
                        end
                        default: begin
                            if (w_last) begin
                                w_state_n = S_IDLE;
                                w_busy_n  = 1'b0;
                                if (!w_is_upd) w_done_n = 1'b1;
                            end else begin
                                w_idx_n  = r_idx + 3'd1;
                                w_cs_n   = 1'b0;
                                w_ph_n   = PH_LOW;
                                w_bit_n  = 4'd15;
                                w_mosi_n = w_next_word[15];
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    assign busy      = r_busy;
    assign init_done = r_done;
    assign spi_cs    = r_cs;
    assign spi_clk   = r_sclk;
    assign spi_mosi  = r_mosi;

endmodule

// File: tb/tb_display_spi_sender.sv
// Bench for display_spi_sender: two instances (CLK_DIV=4 and CLK_DIV=1).
// SPI monitors decode frames and compare them against expected-frame queues
// filled by the scenario tasks.
module tb_display_spi_sender;

    logic       clk_in = 1'b0;
    logic       res = 1'b1, start = 1'b0;
    logic       res2 = 1'b1, start2 = 1'b0;
    logic [2:0] min_X0 = '0, sec_X0 = '0;
    logic [3:0] min_0X = '0, sec_0X = '0, ces_X0 = '0, ces_0X = '0;
    logic       busy, init_done, spi_cs, spi_clk, spi_mosi;
    logic       busy2, init_done2, spi_cs2, spi_clk2, spi_mosi2;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp1_q[$];
    logic [15:0] exp2_q[$];
    int rx1 = 0, rx2 = 0;

    always #5 clk_in = ~clk_in;

    display_spi_sender dut (
        .clk_in(clk_in), .res(res), .start(start),
        .min_X0(min_X0), .min_0X(min_0X), .sec_X0(sec_X0), .sec_0X(sec_0X),
        .ces_X0(ces_X0), .ces_0X(ces_0X),
        .busy(busy), .init_done(init_done),
        .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi)
    );

    display_spi_sender #(.CLK_DIV(1)) dut2 (
        .clk_in(clk_in), .res(res2), .start(start2),
        .min_X0(min_X0), .min_0X(min_0X), .sec_X0(sec_X0), .sec_0X(sec_0X),
        .ces_X0(ces_X0), .ces_0X(ces_0X),
        .busy(busy2), .init_done(init_done2),
        .spi_cs(spi_cs2), .spi_clk(spi_clk2), .spi_mosi(spi_mosi2)
    );

    // ---------------- SPI monitor, instance 1 ----------------
    logic [15:0] sh1;
    int          nb1;
    always @(negedge spi_cs) begin sh1 = '0; nb1 = 0; end
    always @(posedge spi_clk) begin sh1 = {sh1[14:0], spi_mosi}; nb1++; end
    always @(posedge spi_cs) begin
        if (res !== 1'b1) begin
            logic [15:0] e;
            tests++;
            rx1++;
            if (exp1_q.size() == 0) begin
                fails++;
                $display("FAIL frame1_unexpected: got %h (%0d bits), none expected", sh1, nb1);
            end else begin
                e = exp1_q.pop_front();
                if (nb1 != 16 || sh1 !== e) begin
                    fails++;
                    $display("FAIL frame1: got %h (%0d bits) want %h (16 bits)", sh1, nb1, e);
                end
            end
        end
    end
    always @(negedge clk_in) begin
        if (spi_cs === 1'b1 && (spi_clk !== 1'b0 || spi_mosi !== 1'b0)) begin
            fails++;
            $display("FAIL idle_lines1: clk=%b mosi=%b while cs high, want 0/0", spi_clk, spi_mosi);
        end
    end

    // ---------------- SPI monitor, instance 2 ----------------
    logic [15:0] sh2;
    int          nb2;
    logic        p_s2 = 1'b0, p_m2 = 1'b0;
    always @(negedge spi_cs2) begin sh2 = '0; nb2 = 0; end
    always @(posedge spi_clk2) begin sh2 = {sh2[14:0], spi_mosi2}; nb2++; end
    always @(posedge spi_cs2) begin
        if (res2 !== 1'b1) begin
            logic [15:0] e;
            tests++;
            rx2++;
            if (exp2_q.size() == 0) begin
                fails++;
                $display("FAIL frame2_unexpected: got %h (%0d bits), none expected", sh2, nb2);
            end else begin
                e = exp2_q.pop_front();
                if (nb2 != 16 || sh2 !== e) begin
                    fails++;
                    $display("FAIL frame2: got %h (%0d bits) want %h (16 bits)", sh2, nb2, e);
                end
            end
        end
    end
    // mosi must hold across every rising spi_clk (sampled once per cycle)
    always @(negedge clk_in) begin
        if (!p_s2 && spi_clk2 === 1'b1) begin
            tests++;
            if (spi_mosi2 !== p_m2) begin
                fails++;
                $display("FAIL mosi_stable2: mosi=%b at clk rise, was %b", spi_mosi2, p_m2);
            end
        end
        if (spi_cs2 === 1'b1 && spi_clk2 !== 1'b0) begin
            fails++;
            $display("FAIL idle_clk2: clk=%b while cs high, want 0", spi_clk2);
        end
        p_s2 = (spi_clk2 === 1'b1);
        p_m2 = spi_mosi2;
    end

    // ---------------- expected-frame model ----------------
    task automatic push_init(input bit second);
        logic [15:0] w[5];
        w = '{16'h0F00, 16'h0B05, 16'h09FF, 16'h0A0A, 16'h0C01};
        foreach (w[i]) if (second) exp2_q.push_back(w[i]); else exp1_q.push_back(w[i]);
    endtask

    task automatic push_update(input bit second, input logic [2:0] mx0, input logic [3:0] m0x,
                               input logic [2:0] sx0, input logic [3:0] s0x,
                               input logic [3:0] cx0, input logic [3:0] c0x);
        logic [15:0] w[6];
        w = '{{8'h01, 4'h0, c0x}, {8'h02, 4'h0, cx0}, {8'h03, 4'h8, s0x},
              {8'h04, 5'h00, sx0}, {8'h05, 4'h8, m0x}, {8'h06, 5'h00, mx0}};
        foreach (w[i]) if (second) exp2_q.push_back(w[i]); else exp1_q.push_back(w[i]);
    endtask

    task automatic set_digits(input logic [2:0] mx0, input logic [3:0] m0x,
                              input logic [2:0] sx0, input logic [3:0] s0x,
                              input logic [3:0] cx0, input logic [3:0] c0x);
        min_X0 = mx0; min_0X = m0x; sec_X0 = sx0; sec_0X = s0x; ces_X0 = cx0; ces_0X = c0x;
    endtask

    // Counts busy cycles of instance 1 (cnt already includes the first one),
    // raising start for one cycle whenever the count equals pa or pb.
    task automatic count_busy(input int limit, input int pa, input int pb, inout int cnt);
        while (busy === 1'b1 && cnt < limit) begin
            @(posedge clk_in); #1;
            if (busy === 1'b1) cnt++;
            start = (cnt == pa || cnt == pb);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        tests++; if (spi_cs !== 1'b1)    begin fails++; $display("FAIL rst_cs: %b want 1", spi_cs); end
        tests++; if (spi_clk !== 1'b0)   begin fails++; $display("FAIL rst_clk: %b want 0", spi_clk); end
        tests++; if (spi_mosi !== 1'b0)  begin fails++; $display("FAIL rst_mosi: %b want 0", spi_mosi); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: %b want 0", busy); end
        tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL rst_done: %b want 0", init_done); end
    endtask

    task automatic test_init();
        int cnt;
        push_init(1'b0);
        res = 1'b0;
        @(posedge clk_in); #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL init_busy_rise: %b want 1", busy); end
        tests++; if (spi_cs !== 1'b0) begin fails++; $display("FAIL init_cs_fall: %b want 0", spi_cs); end
        cnt = 1;
        // start during INIT and on the cycle busy falls: both dropped
        count_busy(2000, 100, 680, cnt);
        tests++; if (cnt != 680) begin fails++; $display("FAIL init_len: %0d cycles want 680", cnt); end
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_done: %b want 1", init_done); end
        tests++; if (rx1 != 5) begin fails++; $display("FAIL init_frames: %0d want 5", rx1); end
        tests++; if (exp1_q.size() != 0) begin fails++; $display("FAIL init_missing: %0d left want 0", exp1_q.size()); end
        repeat (300) @(posedge clk_in);
        #1;
        tests++; if (busy !== 1'b0 || rx1 != 5) begin
            fails++; $display("FAIL init_drop_start: busy=%b frames=%0d want 0/5", busy, rx1);
        end
    endtask

    task automatic test_update();
        int cnt, base;
        base = rx1;
        set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
        push_update(1'b0, 3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
        pulse_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL upd_busy_rise: %b want 1", busy); end
        cnt = 1;
        // start mid-update and on the busy-fall cycle: both dropped
        count_busy(2000, 300, 816, cnt);
        tests++; if (cnt != 816) begin fails++; $display("FAIL upd_len: %0d cycles want 816", cnt); end
        tests++; if (rx1 - base != 6) begin fails++; $display("FAIL upd_frames: %0d want 6", rx1 - base); end
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL upd_done_sticky: %b want 1", init_done); end
        repeat (300) @(posedge clk_in);
        #1;
        tests++; if (busy !== 1'b0 || rx1 - base != 6) begin
            fails++; $display("FAIL upd_drop_start: busy=%b frames=%0d want 0/6", busy, rx1 - base);
        end
    endtask

    task automatic test_snapshot();
        int cnt, base;
        base = rx1;
        set_digits(3'd5, 4'd9, 3'd5, 4'd8, 4'hC, 4'hB);
        push_update(1'b0, 3'd5, 4'd9, 3'd5, 4'd8, 4'hC, 4'hB);
        pulse_start();
        set_digits(3'd2, 4'd0, 3'd1, 4'd7, 4'd3, 4'd3);
        cnt = 1;
        count_busy(2000, -1, -1, cnt);
        tests++; if (cnt != 816) begin fails++; $display("FAIL snap_len: %0d cycles want 816", cnt); end
        tests++; if (rx1 - base != 6 || exp1_q.size() != 0) begin
            fails++; $display("FAIL snap_frames: %0d rx, %0d left want 6/0", rx1 - base, exp1_q.size());
        end
    endtask

    task automatic test_reset_mid_update();
        int cnt, base;
        set_digits(3'd4, 4'd1, 3'd2, 4'd0, 4'd9, 4'd9);
        push_update(1'b0, 3'd4, 4'd1, 3'd2, 4'd0, 4'd9, 4'd9);
        pulse_start();
        repeat (311) @(posedge clk_in);
        #1;
        tests++; if (spi_cs !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL mid_frame3: cs=%b busy=%b want 0/1", spi_cs, busy);
        end
        res = 1'b1;
        #1;
        tests++; if (spi_cs !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin
            fails++; $display("FAIL abort_lines: cs=%b clk=%b mosi=%b want 1/0/0", spi_cs, spi_clk, spi_mosi);
        end
        tests++; if (busy !== 1'b0 || init_done !== 1'b0) begin
            fails++; $display("FAIL abort_flags: busy=%b done=%b want 0/0", busy, init_done);
        end
        exp1_q.delete();
        base = rx1;
        repeat (3) @(posedge clk_in);
        #1;
        push_init(1'b0);
        res = 1'b0;
        @(posedge clk_in); #1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reinit_busy: %b want 1", busy); end
        cnt = 1;
        count_busy(2000, -1, -1, cnt);
        tests++; if (cnt != 680 || init_done !== 1'b1) begin
            fails++; $display("FAIL reinit_len: %0d cycles done=%b want 680/1", cnt, init_done);
        end
        tests++; if (rx1 - base != 5) begin fails++; $display("FAIL reinit_frames: %0d want 5", rx1 - base); end
    endtask

    task automatic test_clkdiv1();
        int cnt, k, r1, r2, cf;
        logic ps, pc;
        set_digits(3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'hF);
        push_init(1'b1);
        push_update(1'b1, 3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'hF);
        res2 = 1'b0;
        k = 0;
        while (init_done2 !== 1'b1 && k < 400) begin @(posedge clk_in); #1; k++; end
        tests++; if (init_done2 !== 1'b1 || busy2 !== 1'b0 || rx2 != 5) begin
            fails++; $display("FAIL d1_init: done=%b busy=%b frames=%0d want 1/0/5", init_done2, busy2, rx2);
        end
        start2 = 1'b1;
        @(posedge clk_in); #1;
        start2 = 1'b0;
        tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL d1_busy_rise: %b want 1", busy2); end
        cnt = 1; r1 = -1; r2 = -1; cf = -1;
        ps = spi_clk2; pc = spi_cs2;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_in); #1;
            if (busy2 === 1'b1) cnt++;
            if (!ps && spi_clk2 === 1'b1) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            if (pc && spi_cs2 === 1'b0 && cf < 0) cf = i;
            ps = spi_clk2; pc = spi_cs2;
        end
        tests++; if (r2 - r1 != 2) begin fails++; $display("FAIL d1_sclk_period: %0d want 2", r2 - r1); end
        tests++; if (cf != 34) begin fails++; $display("FAIL d1_frame_period: %0d want 34", cf); end
        while (busy2 === 1'b1 && cnt < 1000) begin
            @(posedge clk_in); #1;
            if (busy2 === 1'b1) cnt++;
        end
        tests++; if (cnt != 204) begin fails++; $display("FAIL d1_upd_len: %0d want 204", cnt); end
        tests++; if (rx2 != 11 || exp2_q.size() != 0) begin
            fails++; $display("FAIL d1_frames: %0d rx, %0d left want 11/0", rx2, exp2_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_update();
        test_snapshot();
        test_reset_mid_update();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
